// File: rtl/ad9739_pkg.sv
// Shared types and constants for the AD9739 power-up sequencer.
// Retry behaviour is selected with the AD9739_RETRY_EN macro in ad9739_init_seq.
package ad9739_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrMu,
    StWaitMu,
    StRdMu,
    StWrLvds,
    StWaitLvds,
    StRdLvds,
    StDone,
    StFail
  } seq_state_e;

  localparam int unsigned TableDepth = 16;
  localparam int unsigned IdxW       = $clog2(TableDepth);

  localparam logic [IdxW-1:0] MuFirst   = 4'd0;
  localparam logic [IdxW-1:0] MuLast    = 4'd11;
  localparam logic [IdxW-1:0] LvdsFirst = 4'd12;
  localparam logic [IdxW-1:0] LvdsLast  = 4'd15;

  localparam logic [6:0] MuStatAddr   = 7'h2A;
  localparam logic [6:0] LvdsStatAddr = 7'h21;

  localparam int unsigned LockBit = 0;

endpackage

// File: rtl/ad9739_init_rom.sv
// Register write table for AD9739 bring-up: MU controller entries 0..11,
// LVDS receiver entries 12..15.
module ad9739_init_rom
  import ad9739_pkg::*;
(
  input  logic [IdxW-1:0] index,
  output logic [6:0]      addr,
  output logic [7:0]      data
);

  always_comb begin
    addr = 7'h00;
    data = 8'h00;
    case (index)
      4'd0:  begin addr = 7'h00; data = 8'h00; end
      4'd1:  begin addr = 7'h00; data = 8'h20; end  // soft reset pulse
      4'd2:  begin addr = 7'h00; data = 8'h00; end
      4'd3:  begin addr = 7'h22; data = 8'h0F; end
      4'd4:  begin addr = 7'h23; data = 8'h0F; end
      4'd5:  begin addr = 7'h24; data = 8'h30; end
      4'd6:  begin addr = 7'h25; data = 8'h80; end
      4'd7:  begin addr = 7'h27; data = 8'h42; end
      4'd8:  begin addr = 7'h28; data = 8'h6C; end
      4'd9:  begin addr = 7'h29; data = 8'hCB; end
      4'd10: begin addr = 7'h26; data = 8'h02; end
      4'd11: begin addr = 7'h26; data = 8'h03; end  // MU enable
      4'd12: begin addr = 7'h13; data = 8'h72; end
      4'd13: begin addr = 7'h10; data = 8'h00; end
      4'd14: begin addr = 7'h10; data = 8'h02; end
      4'd15: begin addr = 7'h10; data = 8'h03; end  // LVDS enable
      default: begin addr = 7'h00; data = 8'h00; end
    endcase
  end

endmodule

// File: rtl/ad9739_init_seq.sv
// AD9739 power-up sequencer: table writes and lock polling over a req/ack SPI engine.
// Define AD9739_RETRY_EN to restart the whole sequence up to MAX_RETRY times on a lock failure.
module ad9739_init_seq
  import ad9739_pkg::*;
#(
  parameter int unsigned WAIT_MU_CYC   = 200,
  parameter int unsigned WAIT_LVDS_CYC = 169,
  parameter int unsigned POLL_MAX      = 16,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       spi_req,
  output logic       spi_rw,
  output logic [6:0] spi_addr,
  output logic [7:0] spi_wdata,
  input  logic       spi_ack,
  input  logic [7:0] spi_rdata,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       fail_phase
);

  localparam int unsigned WaitMax = (WAIT_MU_CYC > WAIT_LVDS_CYC) ? WAIT_MU_CYC : WAIT_LVDS_CYC;
  localparam int unsigned WaitW   = (WaitMax > 1) ? $clog2(WaitMax) : 1;
  localparam int unsigned PollW   = $clog2(POLL_MAX + 1);

  localparam logic [WaitW-1:0] WaitMuLast   = WaitW'(WAIT_MU_CYC - 1);
  localparam logic [WaitW-1:0] WaitLvdsLast = WaitW'(WAIT_LVDS_CYC - 1);
  localparam logic [PollW-1:0] PollLast     = PollW'(POLL_MAX - 1);

  seq_state_e       state;
  logic [IdxW-1:0]  idx;
  logic [WaitW-1:0] wait_cnt;
  logic [PollW-1:0] poll_cnt;
  logic [6:0]       rom_addr;
  logic [7:0]       rom_data;
  logic             lock;
  logic             xfer_done;
  logic             retry_ok;
  logic             unused_rdata;

  assign lock         = spi_rdata[LockBit];
  assign xfer_done    = spi_req & spi_ack;
  assign unused_rdata = ^spi_rdata;

  ad9739_init_rom u_rom (
    .index (idx),
    .addr  (rom_addr),
    .data  (rom_data)
  );

`ifdef AD9739_RETRY_EN
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RetryW-1:0] retry_cnt;
  logic              start_ok;
  logic              phase_fail;

  assign start_ok   = start & (state == StIdle || state == StDone || state == StFail);
  assign phase_fail = xfer_done & ~lock & (poll_cnt == PollLast) &
                      (state == StRdMu || state == StRdLvds);
  assign retry_ok   = (retry_cnt < RetryW'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if (start_ok) begin
      retry_cnt <= '0;
    end else if (phase_fail && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  logic unused_max_retry;

  assign retry_ok         = 1'b0;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      idx        <= MuFirst;
      wait_cnt   <= '0;
      poll_cnt   <= '0;
      spi_req    <= 1'b0;
      spi_rw     <= 1'b0;
      spi_addr   <= 7'h00;
      spi_wdata  <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_phase <= 1'b0;
    end else begin
      case (state)
        StIdle, StDone, StFail: begin
          if (start) begin
            state      <= StWrMu;
            idx        <= MuFirst;
            wait_cnt   <= '0;
            poll_cnt   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_phase <= 1'b0;
          end
        end

        // The cycle after an ack has req low, which gives the mandatory idle gap.
        StWrMu, StWrLvds: begin
          if (!spi_req) begin
            spi_req   <= 1'b1;
            spi_rw    <= 1'b0;
            spi_addr  <= rom_addr;
            spi_wdata <= rom_data;
          end else if (spi_ack) begin
            spi_req <= 1'b0;
            if (state == StWrMu && idx == MuLast) begin
              state    <= StWaitMu;
              wait_cnt <= '0;
              poll_cnt <= '0;
            end else if (state == StWrLvds && idx == LvdsLast) begin
              state    <= StWaitLvds;
              wait_cnt <= '0;
              poll_cnt <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        // Read request is launched on the last wait cycle so req-low spans exactly the wait.
        StWaitMu, StWaitLvds: begin
          if (wait_cnt == ((state == StWaitMu) ? WaitMuLast : WaitLvdsLast)) begin
            wait_cnt  <= '0;
            state     <= (state == StWaitMu) ? StRdMu : StRdLvds;
            spi_req   <= 1'b1;
            spi_rw    <= 1'b1;
            spi_addr  <= (state == StWaitMu) ? MuStatAddr : LvdsStatAddr;
            spi_wdata <= 8'h00;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        StRdMu, StRdLvds: begin
          if (xfer_done) begin
            spi_req <= 1'b0;
            if (lock) begin
              if (state == StRdMu) begin
                state <= StWrLvds;
                idx   <= LvdsFirst;
              end else begin
                state <= StDone;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else if (poll_cnt == PollLast) begin
              if (retry_ok) begin
                state    <= StWrMu;
                idx      <= MuFirst;
                wait_cnt <= '0;
                poll_cnt <= '0;
              end else begin
                state      <= StFail;
                busy       <= 1'b0;
                fail       <= 1'b1;
                fail_phase <= (state == StRdLvds);
              end
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              wait_cnt <= '0;
              state    <= (state == StRdMu) ? StWaitMu : StWaitLvds;
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
